aes_loopback_bist_ctrl: RTL

//  Built-in self-test sequencer for the AES-128 encrypt->decrypt loopback (AES_enc feeding AES_dec).

---
 rtl/aes_loopback_bist_ctrl_if.sv | 23 ++
 rtl/aes_loopback_bist_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aes_loopback_bist_ctrl_if.sv
// Core-side bus between the loopback BIST controller and the AES encrypt/decrypt pair.
interface aes_loopback_bist_ctrl_if;
  logic [127:0] pt_out;
  logic [127:0] key_out;
  logic         enable_enc;
  logic         fsm_en_enc;
  logic         enable_dec;
  logic         fsm_en_dec;
  logic [127:0] ct_in;
  logic         enc_valid_in;
  logic [127:0] pt_final_in;
  logic         dec_valid_in;

  modport master (
    output pt_out, key_out, enable_enc, fsm_en_enc, enable_dec, fsm_en_dec,
    input  ct_in, enc_valid_in, pt_final_in, dec_valid_in
  );

  modport slave (
    input  pt_out, key_out, enable_enc, fsm_en_enc, enable_dec, fsm_en_dec,
    output ct_in, enc_valid_in, pt_final_in, dec_valid_in
  );
endinterface

// File: rtl/aes_loopback_bist_ctrl.sv
// BIST sequencer for an AES-128 encrypt->decrypt loopback: issues LFSR plaintexts,
// checks the decryptor output stream, folds a ciphertext signature, reports pass/fail/timeout.
module aes_loopback_bist_ctrl #(
  parameter int unsigned  NUM_VEC   = 256,
  parameter logic [127:0] SEED      = 128'h1,
  parameter int unsigned  KEY_SETUP = 10,
  parameter int unsigned  MAX_OUTST = 32,
  parameter int unsigned  TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [127:0]            key_in,
  aes_loopback_bist_ctrl_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic [15:0]             first_err_idx,
  output logic [31:0]             ct_signature
);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_t;

  localparam logic [127:0] SEED_EFF   = (SEED == 128'h0) ? 128'h1 : SEED;
  localparam logic [15:0]  LAST_VEC   = 16'(NUM_VEC - 1);
  localparam logic [15:0]  SETUP_LAST = (KEY_SETUP == 0) ? 16'h0 : 16'(KEY_SETUP - 1);
  localparam logic [7:0]   OUTST_LIM  = 8'(MAX_OUTST);
  localparam logic [15:0]  IDLE_LAST  = 16'(TIMEOUT - 1);

  state_t       state, state_nxt;
  logic [15:0]  setup_cnt, issue_cnt, idle_cnt, res_idx;
  logic [7:0]   outstanding;
  logic [127:0] gen_lfsr, chk_lfsr;
  logic         busy_st, start_ok, issue_go, chk_hit, spurious, mismatch;
  logic         activity, idle_tick, to_hit, enter_done;
  logic [15:0]  err_nxt;

  function automatic logic [127:0] lfsr_step(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sig_fold(input logic [31:0] s, input logic [127:0] ct);
    return {s[30:0], s[31]} ^ ct[127:96] ^ ct[95:64] ^ ct[63:32] ^ ct[31:0];
  endfunction

  always_comb begin
    busy_st   = (state == SETUP) || (state == ISSUE) || (state == DRAIN);
    start_ok  = start && ((state == IDLE) || (state == DONE));
    issue_go  = (state == ISSUE) && (outstanding < OUTST_LIM);
    // A result is only checkable if something is actually in flight.
    chk_hit   = bus.dec_valid_in && busy_st && (outstanding != 8'd0);
    spurious  = bus.dec_valid_in && !chk_hit;
    mismatch  = chk_hit && (bus.pt_final_in != chk_lfsr);
    err_nxt   = (mismatch || spurious) ? sat_inc(err_count) : err_count;
    activity  = issue_go || bus.enc_valid_in || bus.dec_valid_in;
    idle_tick = busy_st && !activity && (outstanding != 8'd0);
    to_hit    = idle_tick && (idle_cnt == IDLE_LAST);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = SETUP;
      SETUP:      if (setup_cnt == SETUP_LAST) state_nxt = ISSUE;
      ISSUE:      if (issue_go && (issue_cnt == LAST_VEC)) state_nxt = DRAIN;
      DRAIN:      if (outstanding == 8'd0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (to_hit) state_nxt = DONE;
  end

  assign enter_done     = (state_nxt == DONE) && (state != DONE);
  assign busy           = busy_st;
  assign bus.fsm_en_enc = busy_st;
  assign bus.fsm_en_dec = busy_st;
  assign bus.enable_dec = bus.enc_valid_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pt_out     <= '0;
      bus.key_out    <= '0;
      bus.enable_enc <= 1'b0;
      gen_lfsr       <= SEED_EFF;
      chk_lfsr       <= SEED_EFF;
      setup_cnt      <= '0;
      issue_cnt      <= '0;
      idle_cnt       <= '0;
      res_idx        <= '0;
      outstanding    <= '0;
      err_count      <= '0;
      first_err_idx  <= 16'hFFFF;
      ct_signature   <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
    end else if (start_ok) begin
      bus.key_out    <= key_in;
      bus.enable_enc <= 1'b0;
      gen_lfsr       <= SEED_EFF;
      chk_lfsr       <= SEED_EFF;
      setup_cnt      <= '0;
      issue_cnt      <= '0;
      idle_cnt       <= '0;
      res_idx        <= '0;
      outstanding    <= '0;
      err_count      <= '0;
      first_err_idx  <= 16'hFFFF;
      ct_signature   <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      bus.enable_enc <= issue_go;
      if (issue_go) begin
        bus.pt_out <= gen_lfsr;
        gen_lfsr   <= lfsr_step(gen_lfsr);
        issue_cnt  <= issue_cnt + 16'd1;
      end
      if (state == SETUP) setup_cnt <= setup_cnt + 16'd1;
      if (chk_hit) begin
        chk_lfsr <= lfsr_step(chk_lfsr);
        res_idx  <= res_idx + 16'd1;
        if (mismatch && (first_err_idx == 16'hFFFF)) first_err_idx <= res_idx;
      end
      err_count <= err_nxt;
      case ({issue_go, chk_hit})
        2'b10:   outstanding <= outstanding + 8'd1;
        2'b01:   outstanding <= outstanding - 8'd1;
        default: ;
      endcase
      if (idle_tick)                                 idle_cnt <= idle_cnt + 16'd1;
      else if (activity || (outstanding == 8'd0))    idle_cnt <= '0;
      if (bus.enc_valid_in && busy_st) ct_signature <= sig_fold(ct_signature, bus.ct_in);
      if (enter_done) begin
        done    <= 1'b1;
        timeout <= to_hit;
        pass    <= (err_nxt == 16'd0) && !to_hit;
      end
    end
  end
endmodule
